// File: rtl/mem_resp_types.sv
// Shared types and defaults for the mem_responder word-memory slave.
package mem_resp_types;

    localparam int unsigned DEFAULT_DEPTH   = 1024;
    localparam int unsigned DEFAULT_LATENCY = 3;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} mem_resp_state_t;

    typedef enum logic {op_rd, op_wr} mem_op_t;

    function automatic int unsigned word_idx_w(int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int unsigned WORD_IDX_W = word_idx_w(DEFAULT_DEPTH);
    typedef logic [WORD_IDX_W-1:0] word_idx_t;

endpackage

// File: rtl/mem_responder_if.sv
// mem_read/mem_write/mem_resp handshake between the datapath control FSM and the memory.
// MEM_RESPONDER_ERR_EN adds the mem_err response line.
interface mem_responder_if;

    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_rdata;
    logic        mem_resp;

`ifdef MEM_RESPONDER_ERR_EN
    logic        mem_err;

    modport master (
        output mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
        input  mem_rdata, mem_resp, mem_err
    );
    modport slave (
        input  mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
        output mem_rdata, mem_resp, mem_err
    );
`else
    modport master (
        output mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
        input  mem_rdata, mem_resp
    );
    modport slave (
        input  mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
        output mem_rdata, mem_resp
    );
`endif

endinterface

// File: rtl/mem_resp_array.sv
// Byte-enabled word SRAM: synchronous write, synchronous read, no reset on contents.
module mem_resp_array
    import mem_resp_types::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    parameter int unsigned IDX_W = word_idx_w(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [3:0]       be,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        rdata <= mem[idx];
    end

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency slave for the multicycle datapath memory handshake.
// Define MEM_RESPONDER_ERR_EN to flag and suppress out-of-range or read+write requests.
module mem_responder
    import mem_resp_types::*;
#(
    parameter int unsigned DEPTH   = DEFAULT_DEPTH,
    parameter int unsigned LATENCY = DEFAULT_LATENCY
) (
    input  logic            clk,
    input  logic            rst,
    mem_responder_if.slave  bus
);

    localparam int unsigned IdxW        = word_idx_w(DEPTH);
    localparam logic [3:0]  CntLoad     = 4'(LATENCY - 1);
    localparam bit          SingleCycle = (LATENCY == 1);

    mem_resp_state_t  state_q;
    mem_op_t          op_q;
    logic [IdxW-1:0]  idx_q;
    logic [31:0]      wdata_q;
    logic [3:0]       be_q;
    logic             err_q;
    logic [3:0]       cnt_q;
    logic             resp_q;
    logic             show_q;
    logic             err_out_q;
    logic [31:0]      last_q;

    logic             req;
    logic             accept;
    logic             enter_resp;
    logic             req_err;
    mem_op_t          req_op;
    mem_op_t          cur_op;
    logic [IdxW-1:0]  cur_idx;
    logic [31:0]      cur_wdata;
    logic [3:0]       cur_be;
    logic             cur_err;
    logic             arr_we;
    logic [31:0]      arr_rdata;
    logic [31:0]      rdata_now;

    assign req    = bus.mem_read | bus.mem_write;
    // The RESP cycle also accepts, giving one access per LATENCY+1 cycles.
    assign accept = req && (state_q == IDLE || state_q == RESP);
    assign req_op = bus.mem_write ? op_wr : op_rd;

`ifdef MEM_RESPONDER_ERR_EN
    assign req_err = (bus.mem_read & bus.mem_write) | (bus.mem_address[31:2] >= 30'(DEPTH));
`else
    assign req_err = 1'b0;
`endif

    // With LATENCY==1 the array access happens on the accept edge, so it sees the live request.
    assign cur_op    = accept ? req_op : op_q;
    assign cur_idx   = accept ? bus.mem_address[2 +: IdxW] : idx_q;
    assign cur_wdata = accept ? bus.mem_wdata : wdata_q;
    assign cur_be    = accept ? bus.mem_byte_enable : be_q;
    assign cur_err   = accept ? req_err : err_q;

    assign enter_resp = (accept && SingleCycle) || (state_q == WAIT && cnt_q == 4'd0);
    assign arr_we     = enter_resp && (cur_op == op_wr) && !cur_err && !rst;

    mem_resp_array #(
        .DEPTH (DEPTH),
        .IDX_W (IdxW)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .be    (cur_be),
        .idx   (cur_idx),
        .wdata (cur_wdata),
        .rdata (arr_rdata)
    );

    assign rdata_now = err_q ? 32'h0 : arr_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            op_q      <= op_rd;
            idx_q     <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            resp_q    <= 1'b0;
            show_q    <= 1'b0;
            err_out_q <= 1'b0;
            last_q    <= '0;
        end else begin
            resp_q    <= enter_resp;
            show_q    <= enter_resp && (cur_op == op_rd);
            err_out_q <= enter_resp && cur_err;
            if (show_q) last_q <= rdata_now;

            if (accept) begin
                op_q    <= req_op;
                idx_q   <= bus.mem_address[2 +: IdxW];
                wdata_q <= bus.mem_wdata;
                be_q    <= bus.mem_byte_enable;
                err_q   <= req_err;
                cnt_q   <= CntLoad;
                state_q <= SingleCycle ? RESP : WAIT;
            end else begin
                case (state_q)
                    WAIT: begin
                        if (cnt_q == 4'd0) state_q <= RESP;
                        else               cnt_q   <= cnt_q - 4'd1;
                    end
                    RESP:    state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    // Read data is live from the array during a read RESP and held afterwards.
    assign bus.mem_rdata = show_q ? rdata_now : last_q;
    assign bus.mem_resp  = resp_q;

`ifdef MEM_RESPONDER_ERR_EN
    assign bus.mem_err = err_out_q;
`else
    logic unused_err;
    assign unused_err = err_out_q;
`endif

    logic unused_addr;
    assign unused_addr = ^bus.mem_address;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized self-checking bench for mem_responder against a word-array reference model.
module tb_mem_responder;

    localparam int unsigned DEPTH   = 1024;
    localparam int unsigned LATENCY = 3;
    localparam int          Lat     = int'(LATENCY);

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    mem_responder_if bus ();

    mem_responder #(
        .DEPTH   (DEPTH),
        .LATENCY (LATENCY)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] ref_mem [8];
`ifdef MEM_RESPONDER_ERR_EN
    bit last_err;
`endif

    task automatic idle_bus();
        bus.mem_read        = 1'b0;
        bus.mem_write       = 1'b0;
        bus.mem_address     = 32'h0;
        bus.mem_wdata       = 32'h0;
        bus.mem_byte_enable = 4'h0;
    endtask

    // Drives one request, returns edges from acceptance to the first mem_resp and the read data.
    task automatic do_op(input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] be,
                         output logic [31:0] rdata, output int lat, output bit single);
        @(negedge clk);
        bus.mem_read        = rd;
        bus.mem_write       = wr;
        bus.mem_address     = addr;
        bus.mem_wdata       = data;
        bus.mem_byte_enable = be;
        @(posedge clk);
        lat    = -1;
        rdata  = 32'h0;
        single = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (bus.mem_resp) begin
                lat   = k;
                rdata = bus.mem_rdata;
`ifdef MEM_RESPONDER_ERR_EN
                last_err = bus.mem_err;
`endif
                break;
            end
        end
        idle_bus();
        @(posedge clk);
        #1;
        single = !bus.mem_resp;
    endtask

    task automatic test_reset();
        idle_bus();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (bus.mem_resp !== 1'b0 || bus.mem_rdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_hold: resp=%b rdata=%h required resp=0 rdata=0",
                     bus.mem_resp, bus.mem_rdata);
        end
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            tests_run++;
            if (bus.mem_resp !== 1'b0 || bus.mem_rdata !== 32'h0) begin
                tests_failed++;
                $display("FAIL reset_idle cycle %0d: resp=%b rdata=%h required resp=0 rdata=0",
                         c, bus.mem_resp, bus.mem_rdata);
            end
        end
    endtask

    task automatic test_full_write();
        logic [31:0] rdata;
        int lat;
        bit single;
        do_op(1'b0, 1'b1, 32'h40, 32'hDEADBEEF, 4'b1111, rdata, lat, single);
        tests_run++;
        if (lat !== Lat || !single) begin
            tests_failed++;
            $display("FAIL full_write_timing: lat=%0d single=%b required lat=%0d single=1",
                     lat, single, Lat);
        end
        do_op(1'b1, 1'b0, 32'h40, 32'h0, 4'b0000, rdata, lat, single);
        tests_run++;
        if (lat !== Lat || !single) begin
            tests_failed++;
            $display("FAIL full_read_timing: lat=%0d single=%b required lat=%0d single=1",
                     lat, single, Lat);
        end
        tests_run++;
        if (rdata !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL full_read_data: got %h required %h", rdata, 32'hDEADBEEF);
        end
    endtask

    task automatic test_partial();
        logic [31:0] rdata;
        int lat;
        bit single;
        do_op(1'b0, 1'b1, 32'h40, 32'h000000AA, 4'b0001, rdata, lat, single);
        do_op(1'b1, 1'b0, 32'h40, 32'h0, 4'b0000, rdata, lat, single);
        tests_run++;
        if (rdata !== 32'hDEADBEAA || lat !== Lat) begin
            tests_failed++;
            $display("FAIL partial_lane0: got %h lat %0d required %h lat %0d",
                     rdata, lat, 32'hDEADBEAA, Lat);
        end
        do_op(1'b0, 1'b1, 32'h40, 32'h12340000, 4'b1100, rdata, lat, single);
        do_op(1'b1, 1'b0, 32'h40, 32'h0, 4'b0000, rdata, lat, single);
        tests_run++;
        if (rdata !== 32'h1234BEAA || lat !== Lat) begin
            tests_failed++;
            $display("FAIL partial_upper: got %h lat %0d required %h lat %0d",
                     rdata, lat, 32'h1234BEAA, Lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rdata;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] v44;
        int lat;
        int t1;
        int t2;
        bit single;
        v44 = $urandom;
        do_op(1'b0, 1'b1, 32'h44, v44, 4'b1111, rdata, lat, single);
        @(negedge clk);
        bus.mem_read    = 1'b1;
        bus.mem_address = 32'h40;
        @(posedge clk);
        t1 = -1;
        t2 = -1;
        d1 = 32'h0;
        d2 = 32'h0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (bus.mem_resp) begin
                t1 = k;
                d1 = bus.mem_rdata;
                bus.mem_address = 32'h44;
                break;
            end
        end
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (bus.mem_resp) begin
                t2 = k;
                d2 = bus.mem_rdata;
                break;
            end
        end
        idle_bus();
        tests_run++;
        if (t1 !== Lat || t2 !== Lat + 1) begin
            tests_failed++;
            $display("FAIL b2b_timing: first %0d second %0d required %0d and %0d",
                     t1, t2, Lat, Lat + 1);
        end
        tests_run++;
        if (d1 !== 32'h1234BEAA || d2 !== v44) begin
            tests_failed++;
            $display("FAIL b2b_data: got %h %h required %h %h", d1, d2, 32'h1234BEAA, v44);
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic test_reset_abort();
        logic [31:0] rdata;
        int lat;
        bit single;
        bit saw;
        do_op(1'b0, 1'b1, 32'h80, 32'h1, 4'b1111, rdata, lat, single);
        @(negedge clk);
        bus.mem_write       = 1'b1;
        bus.mem_address     = 32'h80;
        bus.mem_wdata       = 32'h5;
        bus.mem_byte_enable = 4'b1111;
        @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        saw = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (bus.mem_resp) saw = 1'b1;
        end
        idle_bus();
        rst = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (bus.mem_resp) saw = 1'b1;
        end
        tests_run++;
        if (saw !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_no_resp: saw resp=%b required 0", saw);
        end
        do_op(1'b1, 1'b0, 32'h80, 32'h0, 4'b0000, rdata, lat, single);
        tests_run++;
        if (rdata !== 32'h1 || lat !== Lat) begin
            tests_failed++;
            $display("FAIL abort_read: got %h lat %0d required %h lat %0d", rdata, lat, 32'h1, Lat);
        end
    endtask

    task automatic test_random();
        logic [31:0] rdata;
        logic [31:0] data;
        logic [3:0]  be;
        int lat;
        int w;
        bit single;
        for (int i = 0; i < 8; i++) begin
            ref_mem[i] = $urandom;
            do_op(1'b0, 1'b1, 32'h200 + 32'(4 * i), ref_mem[i], 4'b1111, rdata, lat, single);
            tests_run++;
            if (lat !== Lat || !single) begin
                tests_failed++;
                $display("FAIL rand_init %0d: lat=%0d single=%b required lat=%0d single=1",
                         i, lat, single, Lat);
            end
        end
        for (int n = 0; n < 60; n++) begin
            w = $urandom_range(0, 7);
            if ($urandom_range(0, 1) == 1) begin
                data = $urandom;
                be   = 4'($urandom_range(0, 15));
                do_op(1'b0, 1'b1, 32'h200 + 32'(4 * w), data, be, rdata, lat, single);
                for (int l = 0; l < 4; l++) begin
                    if (be[l]) ref_mem[w][8*l +: 8] = data[8*l +: 8];
                end
                tests_run++;
                if (lat !== Lat || !single) begin
                    tests_failed++;
                    $display("FAIL rand_write %0d: lat=%0d single=%b required lat=%0d single=1",
                             n, lat, single, Lat);
                end
            end else begin
                do_op(1'b1, 1'b0, 32'h200 + 32'(4 * w), 32'h0, 4'($urandom), rdata, lat, single);
                tests_run++;
                if (rdata !== ref_mem[w] || lat !== Lat) begin
                    tests_failed++;
                    $display("FAIL rand_read %0d word %0d: got %h lat %0d required %h lat %0d",
                             n, w, rdata, lat, ref_mem[w], Lat);
                end
            end
        end
    endtask

`ifdef MEM_RESPONDER_ERR_EN
    task automatic test_err();
        logic [31:0] rdata;
        int lat;
        bit single;
        do_op(1'b0, 1'b1, 32'h0, 32'h7, 4'b1111, rdata, lat, single);
        tests_run++;
        if (last_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL err_clean_write: err=%b required 0", last_err);
        end
        do_op(1'b0, 1'b1, 32'h1000, 32'hFFFFFFFF, 4'b1111, rdata, lat, single);
        tests_run++;
        if (last_err !== 1'b1 || lat !== Lat) begin
            tests_failed++;
            $display("FAIL err_oob_write: err=%b lat=%0d required err=1 lat=%0d", last_err, lat, Lat);
        end
        do_op(1'b1, 1'b1, 32'h0, 32'h9, 4'b1111, rdata, lat, single);
        tests_run++;
        if (last_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL err_rd_and_wr: err=%b required 1", last_err);
        end
        do_op(1'b1, 1'b0, 32'h0, 32'h0, 4'b0000, rdata, lat, single);
        tests_run++;
        if (rdata !== 32'h7 || last_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL err_no_wrap: got %h err %b required %h err 0", rdata, last_err, 32'h7);
        end
        do_op(1'b1, 1'b0, 32'h1000, 32'h0, 4'b0000, rdata, lat, single);
        tests_run++;
        if (rdata !== 32'h0 || last_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL err_oob_read: got %h err %b required 0 err 1", rdata, last_err);
        end
    endtask
`else
    task automatic test_wrap();
        logic [31:0] rdata;
        int lat;
        bit single;
        do_op(1'b0, 1'b1, 32'h40 + 32'(DEPTH * 4), 32'h3, 4'b1111, rdata, lat, single);
        do_op(1'b1, 1'b0, 32'h40, 32'h0, 4'b0000, rdata, lat, single);
        tests_run++;
        if (rdata !== 32'h3 || lat !== Lat) begin
            tests_failed++;
            $display("FAIL wrap_alias: got %h lat %0d required %h lat %0d", rdata, lat, 32'h3, Lat);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: still running, required finish");
        $fatal(1);
    end

    initial begin
        idle_bus();
        test_reset();
        test_full_write();
        test_partial();
        test_back_to_back();
        test_reset_abort();
        test_random();
`ifdef MEM_RESPONDER_ERR_EN
        test_err();
`else
        test_wrap();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
